register_32: RTL and testbench



---
 rtl/register_32.sv | 77 +++++++
 tb/tb_register_32.sv | 133 +++++++++++++
 2 files changed

// File: rtl/register_32.sv
// register_32 -- load-enabled data register with asynchronous clear.
//
// WIDTH identical bit cells, each a 2:1 hold/load mux feeding a D flip-flop
// that is cleared asynchronously. It is used for register-file entries,
// pipeline latches and PC/IR-style holding registers.
//
// Ports:
//   clock  in   1      rising-edge clock
//   reset  in   1      asynchronous, active-low clear of every stored bit
//   in0    in   WIDTH  data to be loaded
//   sel0   in   1      load enable (1 = load in0, 0 = hold)
//   out0   out  WIDTH  stored value
//   par0   out  1      even-parity bit of the stored value
//                      (present only when REGISTER_PARITY_EN is defined)
//
// Configuration macro: REGISTER_PARITY_EN
//   Defined     : an extra parity flip-flop (same clear, same enable) stores
//                 ^in0 on each load and drives par0.
//   Not defined : par0 and the parity flip-flop are absent.
module register_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0,
  input  logic             sel0,
`ifdef REGISTER_PARITY_EN
  output logic             par0,
`endif
  output logic [WIDTH-1:0] out0
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_d;

  // Bit cells: the mux feeds the flop's own Q back when sel0 is low, so a
  // held value is recaptured every edge rather than clock-gated.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_d[i] = sel0 ? in0[i] : r_q[i];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_q[i] <= 1'b0;
      end else begin
        r_q[i] <= w_d[i];
      end
    end
  end

  assign out0 = r_q;

`ifdef REGISTER_PARITY_EN
  // Even-parity bit: XOR of all data bits, so data plus parity has an even
  // number of ones.
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic r_par;
  logic w_par_d;

  // Parity is computed from in0 at load time and held alongside the data,
  // so par0 always matches out0 without a combinational XOR tree on out0.
  assign w_par_d = sel0 ? even_parity(in0) : r_par;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_par <= 1'b0;
    end else begin
      r_par <= w_par_d;
    end
  end

  assign par0 = r_par;
`endif

endmodule

// File: tb/tb_register_32.sv
module tb_register_32;

  localparam int WIDTH = 32;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] in0;
  logic             sel0;
  logic [WIDTH-1:0] out0;
`ifdef REGISTER_PARITY_EN
  logic             par0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  register_32 #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .in0   (in0),
    .sel0  (sel0),
`ifdef REGISTER_PARITY_EN
    .par0  (par0),
`endif
    .out0  (out0)
  );

  // Period 10: rising edges at 5, 15, 25, ...; falling edges at 10, 20, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    sel0  = 1'b0;
    in0   = '0;

    // Reset held low 0..10; a rising edge at 5 occurs inside reset.
    #2;
    chk("reset_early", out0, 32'h0);
    #5;  // t=7, after the edge at 5
    chk("reset_after_edge", out0, 32'h0);
    #3;  // t=10, falling edge: release reset between rising edges
    reset = 1'b1;

    // No load after release.
    @(negedge clock);
    chk("post_reset_no_load", out0, 32'h0);

    // Load 10.
    sel0 = 1'b1; in0 = 32'd10;
    @(negedge clock);
    chk("load_10", out0, 32'd10);

    // Hold for two cycles while in0 = 32.
    sel0 = 1'b0; in0 = 32'd32;
    @(negedge clock);
    chk("hold_10_c1", out0, 32'd10);
    @(negedge clock);
    chk("hold_10_c2", out0, 32'd10);

    // Load 55, then hold with in0 = 0.
    sel0 = 1'b1; in0 = 32'd55;
    #1;
    chk("no_comb_path", out0, 32'd10);
    @(negedge clock);
    chk("load_55", out0, 32'd55);
    sel0 = 1'b0; in0 = 32'd0;
    @(negedge clock);
    chk("hold_55", out0, 32'd55);

    // Back-to-back loads on consecutive edges.
    sel0 = 1'b1; in0 = 32'hA5A5_5A5A;
    @(negedge clock);
    chk("b2b_first", out0, 32'hA5A5_5A5A);
    in0 = 32'h1234_5678;
    @(negedge clock);
    chk("b2b_second", out0, 32'h1234_5678);

    // Load all ones, then assert reset between edges.
    in0 = 32'hFFFF_FFFF;
    @(negedge clock);
    chk("load_ones", out0, 32'hFFFF_FFFF);
    #2;
    reset = 1'b0;
    #1;  // no rising edge since the falling edge
    chk("async_clear", out0, 32'h0);
    // Rising edge with sel0 = 1 while reset is low: reset wins.
    @(negedge clock);
    chk("reset_overrides_load", out0, 32'h0);
    reset = 1'b1;
    sel0 = 1'b0;
    @(negedge clock);
    chk("post_reset_hold", out0, 32'h0);

    // Load 7 then 3 (parity 1 then 0).
    sel0 = 1'b1; in0 = 32'h0000_0007;
    @(negedge clock);
    chk("load_7", out0, 32'h0000_0007);
`ifdef REGISTER_PARITY_EN
    chk("par_7", {31'b0, par0}, 32'h1);
`endif
    in0 = 32'h0000_0003;
    @(negedge clock);
    chk("load_3", out0, 32'h0000_0003);
`ifdef REGISTER_PARITY_EN
    chk("par_3", {31'b0, par0}, 32'h0);
    in0 = 32'h8000_0000;
    @(negedge clock);
    chk("par_msb", {31'b0, par0}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("par_reset", {31'b0, par0}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
`endif
    sel0 = 1'b0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
